alu_seq_ctrl: RTL and testbench

//  Sequencer placed in front of the shared alu_top datapath. It captures operands and the op code on a start pulse.
//  It holds them stable on the ALU inputs for a programmable settle window, then latches result and overflow.
//  It pulses done and counts completed operations. Display/bin2bcd logic reads the latched
//  res/res_err, so switch bounce on a/b cannot disturb a displayed result.

---
 rtl/alu_seq_ctrl_pkg.sv | 18 +
 rtl/alu_seq_ctrl_if.sv | 23 ++
 rtl/alu_seq_ctrl_settle_cnt.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared state encoding and ALU func codes for the alu_top sequencer.
// Used by alu_seq_ctrl, alu_top and the surrounding display logic.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam logic [1:0] FUNC_ADD = 2'd0;
  localparam logic [1:0] FUNC_SUB = 2'd1;
  localparam logic [1:0] FUNC_MUL = 2'd2;
  localparam logic [1:0] FUNC_DIV = 2'd3;

  localparam int SETTLE_BITS = 4;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Bus between the sequencer (master) and the shared alu_top datapath (slave).
// Operands/op code go out, result and overflow come back.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 6
);

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [1:0]         alu_func;
  logic [2*WIDTH-1:0] alu_out;
  logic               alu_ovf;

  modport master (
    output alu_a, alu_b, alu_func,
    input  alu_out, alu_ovf
  );

  modport slave (
    input  alu_a, alu_b, alu_func,
    output alu_out, alu_ovf
  );

endinterface

// File: rtl/alu_seq_ctrl_settle_cnt.sv
// Settle-window down-counter: load, decrement, zero flag.
// Sized to hold any legal settle value (1..15).
module seq_settle_cnt
  import alu_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   dec,
  input  logic [SETTLE_BITS-1:0] load_val,
  output logic [SETTLE_BITS-1:0] cnt,
  output logic                   zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Operand/result sequencer in front of alu_top; holds inputs for a settle window.
// Optional ALU_SEQ_CHAIN_EN adds a chain input feeding the last result back as A.
module alu_seq_ctrl #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [1:0]         func_in,
  input  logic               clr,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic               chain,
`endif
  alu_seq_ctrl_if.master     alu,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res,
  output logic               res_err,
  output logic [CNT_W-1:0]   op_cnt
);

  import alu_seq_pkg::*;

  localparam logic [SETTLE_BITS-1:0] SETTLE_LD =
    SETTLE_BITS'(SETTLE - 1);

  state_t state, state_nx;

  logic                   accept;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic [SETTLE_BITS-1:0] cnt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       f_q;
  logic [WIDTH-1:0] a_sel;

  seq_settle_cnt u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_LD),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        if (cnt_zero) state_nx = CAPT;
        else          cnt_dec  = 1'b1;
      end
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ALU_SEQ_CHAIN_EN
  // Chained A is the truncated previous result, even after an overflow.
  assign a_sel = chain ? res[WIDTH-1:0] : a_in;
`else
  assign a_sel = a_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      res     <= '0;
      res_err <= 1'b0;
      op_cnt  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == CAPT);
      if (accept) begin
        a_q <= a_sel;
        b_q <= b_in;
        f_q <= func_in;
      end
      if (state == CAPT) begin
        res     <= alu.alu_out;
        res_err <= alu.alu_ovf;
        op_cnt  <= op_cnt + 1'b1;
      end else if (state == IDLE && clr) begin
        res     <= '0;
        res_err <= 1'b0;
        op_cnt  <= '0;
      end
    end
  end

  assign busy         = (state == EXEC) || (state == CAPT);
  assign alu.alu_a    = a_q;
  assign alu.alu_b    = b_q;
  assign alu.alu_func = f_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: timestamp-based transaction model plus literal checks.
// Works with or without ALU_SEQ_CHAIN_EN.
module tb_alu_seq_ctrl;

  localparam int W  = 6;
  localparam int S  = 4;
  localparam int CW = 2;

`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, clr, chain;
  logic [W-1:0]  a_in, b_in;
  logic [1:0]    func_in;
  logic          busy, done, res_err;
  logic [2*W-1:0] res;
  logic [CW-1:0] op_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  alu_seq_ctrl_if #(.WIDTH(W)) alu_bus ();

  alu_seq_ctrl #(
    .WIDTH  (W),
    .SETTLE (S),
    .CNT_W  (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .func_in (func_in),
    .clr     (clr),
`ifdef ALU_SEQ_CHAIN_EN
    .chain   (chain),
`endif
    .alu     (alu_bus),
    .busy    (busy),
    .done    (done),
    .res     (res),
    .res_err (res_err),
    .op_cnt  (op_cnt)
  );

  always #5 clk = ~clk;

  // Reference ALU: signed ops, divide-by-zero gives all ones with ovf.
  function automatic logic [2*W:0] alu_fn(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [1:0]   f
  );
    logic signed [2*W-1:0] sa, sb, r;
    logic ovf;
    sa  = {{W{a[W-1]}}, a};
    sb  = {{W{b[W-1]}}, b};
    ovf = 1'b0;
    case (f)
      2'd0: r = sa + sb;
      2'd1: r = sa - sb;
      2'd2: r = sa * sb;
      default: begin
        if (b == '0) begin
          r   = '1;
          ovf = 1'b1;
        end else begin
          r = sa / sb;
        end
      end
    endcase
    return {ovf, r};
  endfunction

  assign {alu_bus.alu_ovf, alu_bus.alu_out} =
    alu_fn(alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_func);

  // Transaction model: accepted at edge k, result lands at edge k+S+1.
  int             k;
  int             cap_edge;
  bit             pend;
  logic [W-1:0]   m_a, m_b;
  logic [1:0]     m_f;
  logic [2*W-1:0] m_res;
  logic           m_err;
  int             m_cnt;
  logic           m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; cap_edge <= 0; pend <= 1'b0;
      m_a <= '0; m_b <= '0; m_f <= '0;
      m_res <= '0; m_err <= 1'b0;
      m_cnt <= 0; m_done <= 1'b0;
    end else begin
      k <= k + 1;
      m_done <= 1'b0;
      if (pend) begin
        if (cap_edge == k + 1) begin
          {m_err, m_res} <= alu_fn(m_a, m_b, m_f);
          m_cnt  <= (m_cnt + 1) % (1 << CW);
          pend   <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        if (clr) begin
          m_res <= '0; m_err <= 1'b0; m_cnt <= 0;
        end
        if (start) begin
          m_a <= (CHAIN_ON && chain) ? m_res[W-1:0] : a_in;
          m_b <= b_in;
          m_f <= func_in;
          pend <= 1'b1;
          cap_edge <= k + 1 + S + 1;
        end
      end
    end
  end

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("busy", 32'(busy), 32'(pend));
      cmp("done", 32'(done), 32'(m_done));
      cmp("res", 32'(res), 32'(m_res));
      cmp("res_err", 32'(res_err), 32'(m_err));
      cmp("op_cnt", 32'(op_cnt), 32'(m_cnt));
      cmp("alu_a", 32'(alu_bus.alu_a), 32'(m_a));
      cmp("alu_b", 32'(alu_bus.alu_b), 32'(m_b));
      cmp("alu_func", 32'(alu_bus.alu_func), 32'(m_f));
    end
  end

  int cyc = 0;
  int done_cnt = 0;
  int dq[$];

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      dq.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic [1:0] f,
                    input logic ch);
    a_in = a; b_in = b; func_in = f;
    chain = ch; start = 1'b1;
    tick();
    start = 1'b0; chain = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) cmp("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    int lat, d0;
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    chain = 1'b0; a_in = '0; b_in = '0; func_in = '0;
    tick();
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_res", 32'(res), 32'd0);
    cmp("rst_cnt", 32'(op_cnt), 32'd0);
    tick();

    // basic add
    op(6'd5, 6'd3, 2'd0, 1'b0);
    wait_done(lat);
    cmp("latency", 32'(lat), 32'(S + 1));
    cmp("add_res", 32'(res), 32'd8);
    cmp("add_err", 32'(res_err), 32'd0);
    cmp("add_cnt", 32'(op_cnt), 32'd1);

    // start during EXEC must be dropped
    d0 = done_cnt;
    op(6'd2, 6'd1, 2'd0, 1'b0);
    tick();
    a_in = 6'd20; b_in = 6'd20; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    repeat (10) tick();
    cmp("ign_dones", 32'(done_cnt - d0), 32'd1);
    cmp("ign_res", 32'(res), 32'd3);

    // divide by zero then clear
    op(6'd9, 6'd0, 2'd3, 1'b0);
    wait_done(lat);
    cmp("dz_err", 32'(res_err), 32'd1);
    cmp("dz_res", 32'(res), 32'hfff);
    repeat (5) tick();
    cmp("dz_hold", 32'(res_err), 32'd1);
    cmp("dz_cnt", 32'(op_cnt), 32'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cmp("clr_res", 32'(res), 32'd0);
    cmp("clr_err", 32'(res_err), 32'd0);
    cmp("clr_cnt", 32'(op_cnt), 32'd0);

    // op counter wrap at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      op(W'($urandom), W'($urandom), 2'(i % 3), 1'b0);
      wait_done(lat);
      cmp("wrap_cnt", 32'(op_cnt), 32'(exp_cnt[i]));
    end

    // held start: one op every S+2 cycles
    dq.delete();
    a_in = 6'd1; b_in = 6'd1; func_in = 2'd0;
    start = 1'b1;
    repeat (4 * (S + 2) + 2) tick();
    start = 1'b0;
    repeat (12) tick();
    cmp("held_cnt", 32'(dq.size() >= 4), 32'd1);
    for (int i = 0; i < 3 && i + 1 < dq.size(); i++)
      cmp("held_period", 32'(dq[i+1] - dq[i]), 32'(S + 2));

    // chain (or plain A when the feature is absent)
    op(6'd3, 6'd4, 2'd0, 1'b0);
    wait_done(lat);
    cmp("pre_chain", 32'(res), 32'd7);
    op(6'd11, 6'd2, 2'd0, 1'b1);
    cmp("chain_a", 32'(alu_bus.alu_a), CHAIN_ON ? 32'd7 : 32'd11);
    wait_done(lat);
    cmp("chain_res", 32'(res), CHAIN_ON ? 32'd9 : 32'd13);

    // async reset in the middle of EXEC
    op(6'd6, 6'd6, 2'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    cmp("mid_busy", 32'(busy), 32'd0);
    cmp("mid_res", 32'(res), 32'd0);
    cmp("mid_cnt", 32'(op_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    op(6'd4, 6'd6, 2'd1, 1'b0);
    wait_done(lat);
    cmp("post_rst_res", 32'(res), 32'hffe);
    cmp("post_rst_cnt", 32'(op_cnt), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      clr     = ($urandom_range(0, 7) == 0);
      chain   = 1'($urandom);
      a_in    = W'($urandom);
      b_in    = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      func_in = 2'($urandom);
      tick();
    end
    start = 1'b0; clr = 1'b0; chain = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
